// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window datapath control.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int KERNEL_SIZE = 3;

endpackage

// File: rtl/tag_delay.sv
// Fixed-latency shift register that aligns the {valid,row,col} window tag
// with the window buffer outputs; cleared by synchronous reset.
module tag_delay #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output logic             valid_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  localparam int TW = 1 + ROW_W + COL_W;

  logic [TW-1:0] sr_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= {valid_i, row_i, col_i};
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign {valid_o, row_o, col_o} = sr_q[LAT-1];

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame scheduler: raster reads from pixel memory into the 3x3 window buffer
// and flags complete windows. Optional stride-2 flagging with WIN_STRIDE2_EN.
// Handshake: a read issues in FETCH only while out_ready is high; its data is
// pushed (pix_en) exactly one cycle later regardless of out_ready.
module window_scan_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH  = 5,
  parameter int IMG_HEIGHT = 5,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int WB_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          pix_en,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  input  logic                          out_ready,
  output state_t                        dbg_state
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = $clog2(NPIX);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int DRN_W = $clog2(WB_LAT + 1) + 1;
  localparam int EDGE  = KERNEL_SIZE - 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               pix_en_q;
  logic [ROW_W-1:0]   r_q, r_d;
  logic [COL_W-1:0]   c_q, c_d;
  logic               frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      drain_q  <= '0;
      pix_en_q <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      pix_en_q <= rd_en;
      r_q      <= r_d;
      c_q      <= c_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    rd_en       = 1'b0;
    done        = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          base_d      = base_addr;
          idx_d       = '0;
          frame_start = 1'b1;
        end
      end
      FETCH: begin
        rd_en = out_ready;
        if (out_ready) begin
          if (idx_q == IDX_W'(NPIX - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      // Hold off done until the last pushed pixel's tag has left the delay line.
      DRAIN: begin
        if (drain_q == DRN_W'(WB_LAT)) state_d = DONE;
        else                           drain_d = drain_q + DRN_W'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign rd_addr   = (state_q == FETCH) ? base_q + ADDR_W'(idx_q) : '0;
  assign pix_en    = pix_en_q;
  assign pix_data  = pix_en_q ? rd_data : '0;
  assign dbg_state = state_q;

  // Raster position of the pixel currently being pushed.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (frame_start) begin
      r_d = '0;
      c_d = '0;
    end else if (pix_en_q) begin
      if (c_q == COL_W'(IMG_WIDTH - 1)) begin
        c_d = '0;
        r_d = r_q + ROW_W'(1);
      end else begin
        c_d = c_q + COL_W'(1);
      end
    end
  end

  logic             tag_v;
  logic [ROW_W-1:0] row_off, tag_row;
  logic [COL_W-1:0] col_off, tag_col;

  assign row_off = r_q - ROW_W'(EDGE);
  assign col_off = c_q - COL_W'(EDGE);

  always_comb begin
    tag_v = pix_en_q && (r_q >= ROW_W'(EDGE)) && (c_q >= COL_W'(EDGE));
`ifdef WIN_STRIDE2_EN
    tag_v = tag_v && !row_off[0] && !col_off[0];
`endif
    tag_row = tag_v ? row_off : '0;
    tag_col = tag_v ? col_off : '0;
  end

  tag_delay #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .LAT   (WB_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (tag_v),
    .row_i   (tag_row),
    .col_i   (tag_col),
    .valid_o (win_valid),
    .row_o   (win_row),
    .col_o   (win_col)
  );

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: per-cycle comparison against a
// frame-level schedule model, plus directed reset/abort/held-start cases.
module tb_window_scan_ctrl;
  import cnn_pkg::*;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int LAT  = 1;
  localparam int NPIX = W * H;
  localparam int RW   = $clog2(H);
  localparam int CW   = $clog2(W);
  localparam int MAXC = 400;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] base_addr;
  logic          busy, done, rd_en, pix_en, win_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, pix_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  state_t        dbg_state;

  always #5 clk = ~clk;

  window_scan_ctrl #(
    .IMG_WIDTH (W), .IMG_HEIGHT (H), .DATA_W (DW), .ADDR_W (AW), .WB_LAT (LAT)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .base_addr (base_addr),
    .busy (busy), .done (done), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data), .pix_en (pix_en), .pix_data (pix_data),
    .win_valid (win_valid), .win_row (win_row), .win_col (win_col),
    .out_ready (out_ready), .dbg_state (dbg_state)
  );

  // Pixel memory: data valid one cycle after rd_en, junk otherwise.
  logic [DW-1:0] mem [65536];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            ordy   [MAXC];
  bit            e_rd   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  bit            e_pix  [MAXC];
  logic [DW-1:0] e_pd   [MAXC];
  bit            e_wv   [MAXC];
  int            e_wr   [MAXC];
  int            e_wc   [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  int            done_cyc;
  int            exp_nwin;

  function automatic bit window_wanted(int row, int col);
`ifdef WIN_STRIDE2_EN
    return (row >= 0) && (col >= 0) && (row % 2 == 0) && (col % 2 == 0);
`else
    return (row >= 0) && (col >= 0);
`endif
  endfunction

  // Reads go out on the first NPIX cycles (from cycle 1) where out_ready is high.
  task automatic build_model(input logic [AW-1:0] base, input int stall_pct,
                             input int lo, input int hi);
    int n;
    int last;
    logic [AW-1:0] a;
    for (int c = 0; c < MAXC; c++) begin
      ordy[c] = !((c >= lo && c <= hi) || ($urandom_range(99) < stall_pct));
      if (c >= MAXC - 60) ordy[c] = 1'b1;
      e_rd[c] = 0; e_addr[c] = '0; e_pix[c] = 0; e_pd[c] = '0;
      e_wv[c] = 0; e_wr[c] = 0; e_wc[c] = 0; e_busy[c] = 0; e_done[c] = 0;
    end
    n = 0;
    last = 0;
    exp_nwin = 0;
    for (int c = 1; n < NPIX; c++) begin
      if (ordy[c]) begin
        a = base + AW'(n);
        e_rd[c] = 1; e_addr[c] = a;
        e_pix[c+1] = 1; e_pd[c+1] = mem[a];
        if (window_wanted(n / W - 2, n % W - 2)) begin
          e_wv[c+1+LAT] = 1;
          e_wr[c+1+LAT] = n / W - 2;
          e_wc[c+1+LAT] = n % W - 2;
          exp_nwin++;
        end
        last = c;
        n++;
      end
    end
    done_cyc = last + LAT + 2;
    for (int c = 1; c <= done_cyc; c++) e_busy[c] = 1;
    e_done[done_cyc] = 1;
  endtask

  // ---------------- driver / monitor ----------------
  logic [DW-1:0] cap [NPIX];
  int npush, nwin, nrd, ndone, done_seen;

  function automatic logic [71:0] pack_cap(int r, int c);
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v = {v[63:0], cap[(r + i) * W + c + j]};
    return v;
  endfunction

  function automatic logic [71:0] pack_mem(logic [AW-1:0] base, int r, int c);
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v = {v[63:0], mem[base + AW'((r + i) * W + c + j)]};
    return v;
  endfunction

  // Entered just after a rising edge (frame cycle 0); leaves just after the
  // rising edge following the last checked cycle.
  task automatic run_frame(input logic [AW-1:0] base, input int stall_pct,
                           input int lo, input int hi, input bit hold, input int abort_at);
    int end_c;
    build_model(base, stall_pct, lo, hi);
    for (int i = 0; i < NPIX; i++) cap[i] = '0;
    npush = 0; nwin = 0; nrd = 0; ndone = 0; done_seen = -1;
    start = 1'b1;
    base_addr = base;
    end_c = (abort_at >= 0) ? abort_at : done_cyc;
    for (int c = 0; c <= end_c; c++) begin
      out_ready = ordy[c];
      if (c == 1) begin
        if (!hold) start = 1'b0;
        else       base_addr = base;
        if (!hold) base_addr = AW'($urandom);
      end
      @(negedge clk);
      chk($sformatf("ctrl@%0d", c), {busy, done}, {e_busy[c], e_done[c]});
      chk($sformatf("rd@%0d", c), {rd_en, rd_en ? rd_addr : '0}, {e_rd[c], e_addr[c]});
      chk($sformatf("pix@%0d", c), {pix_en, pix_en ? pix_data : '0}, {e_pix[c], e_pd[c]});
      chk($sformatf("win@%0d", c), {win_valid, win_row, win_col},
          {e_wv[c], RW'(e_wr[c]), CW'(e_wc[c])});
      if (pix_en && npush < NPIX) cap[npush] = pix_data;
      if (pix_en) npush++;
      if (rd_en) nrd++;
      if (win_valid) nwin++;
      if (done) begin ndone++; done_seen = c; end
      if (e_wv[c])
        chk($sformatf("wdata@%0d", c), pack_cap(e_wr[c], e_wc[c]),
            pack_mem(base, e_wr[c], e_wc[c]));
      if (c == end_c && abort_at >= 0) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    if (abort_at < 0) begin
      chk("reads", nrd, NPIX);
      chk("pushes", npush, NPIX);
      chk("windows", nwin, exp_nwin);
      chk("done_count", ndone, 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle", {busy, done, rd_en, pix_en, win_valid}, '0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 65536; a++) mem[a] = rnd ? DW'($urandom) : DW'(a);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fill_mem(1'b0);
    rst = 1'b1; start = 1'b1; out_ready = 1'b1; base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset", {busy, done, rd_en, rd_addr, pix_en, pix_data, win_valid, win_row, win_col}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    idle(2);

    // Plain frame: pixels 0..24 at base 0, no stalls.
    run_frame(16'd0, 0, -1, -1, 1'b0, -1);
    chk("done_cycle", done_seen, 28);
`ifndef WIN_STRIDE2_EN
    chk("win11_data", pack_cap(1, 1), 72'h060708_0b0c0d_101112);
`endif
    idle(3);

    // out_ready low in cycles 5..9.
    run_frame(16'd0, 0, 5, 9, 1'b0, -1);
    chk("stall_done_cycle", done_seen, 33);
    idle(2);

    // Abort at cycle 10, then restart.
    run_frame(16'd0, 0, -1, -1, 1'b0, 10);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_zero", {busy, done, rd_en, rd_addr, pix_en, pix_data, win_valid, win_row, win_col}, '0);
    @(posedge clk);
    #1;
    idle(4);
    run_frame(16'd0, 0, -1, -1, 1'b0, -1);
    idle(2);

    // start held high: back-to-back frames at base 100, one per IDLE visit.
    run_frame(16'd100, 0, -1, -1, 1'b1, -1);
    run_frame(16'd100, 0, -1, -1, 1'b1, -1);
    start = 1'b0;
    idle(3);

    // Randomized frames: random data, bases (one wrapping), stalls.
    fill_mem(1'b1);
    for (int k = 0; k < 6; k++) begin
      run_frame((k == 0) ? 16'hFFF2 : AW'($urandom), $urandom_range(50), -1, -1,
                1'($urandom_range(1)), -1);
      start = 1'b0;
      idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
